// File: rtl/sensor_frame_sequencer.sv
// Frame sequencer: paces producer requests into IMG_W x IMG_H frames with blanking,
// catches the unstallable producer output in a 2-entry skid buffer, re-emits with sof/eol/eof.
module sensor_frame_sequencer #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int H_BLANK = 4,
  parameter int V_BLANK = 16
) (
  input  logic        sensor_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] num_frames,
  output logic        prod_ready,
  input  logic        prod_valid,
  input  logic [7:0]  prod_pixel,
  output logic [7:0]  out_pixel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eol,
  output logic        out_eof,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        err_ovf
);

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;
  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
  } ent_t;

  localparam logic [15:0] COL_LAST = 16'(IMG_W - 1);
  localparam logic [15:0] ROW_LAST = 16'(IMG_H - 1);
  localparam logic [15:0] HB_LAST  = 16'((H_BLANK > 0) ? H_BLANK - 1 : 0);
  localparam logic [15:0] VB_LAST  = 16'((V_BLANK > 0) ? V_BLANK - 1 : 0);

  state_t      state, state_n;
  logic [15:0] req_col, req_row, rx_col, rx_row, bcnt, num_q;
  logic        stop_pend, ready_q;
  logic [1:0]  occ;
  ent_t [1:0]  slot;
  ent_t        ent_w;
  logic        pop, credit, last_col, last_row, exit_vb, exit_now;
  logic [2:0]  occ_proj;

  // Projected occupancy counts the request still in flight, so a full buffer never gets a third pixel.
  assign pop      = out_valid && out_ready;
  assign occ_proj = {1'b0, occ} - {2'b0, pop} + {2'b0, ready_q};
  assign credit   = occ_proj < 3'd2;
  assign last_col = req_col == COL_LAST;
  assign last_row = req_row == ROW_LAST;
  assign exit_vb  = stop_pend || stop || (num_q != 16'd0 && frame_cnt == num_q);
  assign exit_now = stop_pend || stop || (num_q != 16'd0 && frame_cnt + 16'd1 == num_q);

  always_ff @(posedge sensor_clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (start) state_n = ACTIVE;
      ACTIVE: if (prod_ready && last_col) begin
        if (!last_row)         state_n = (H_BLANK == 0) ? ACTIVE : HBLANK;
        else if (V_BLANK != 0) state_n = VBLANK;
        else if (exit_now)     state_n = IDLE;
      end
      HBLANK: if (bcnt == HB_LAST) state_n = ACTIVE;
      VBLANK: if (bcnt == VB_LAST) state_n = exit_vb ? IDLE : ACTIVE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    prod_ready = (state == ACTIVE) && credit;
    busy       = state != IDLE;
  end

  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      num_q     <= '0;
      frame_cnt <= '0;
      stop_pend <= 1'b0;
      req_col   <= '0;
      req_row   <= '0;
      bcnt      <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= prod_ready;
      bcnt    <= ((state == HBLANK || state == VBLANK) && state_n == state) ? bcnt + 16'd1 : '0;
      if (state == IDLE) begin
        if (start) begin
          num_q     <= num_frames;
          frame_cnt <= '0;
          stop_pend <= 1'b0;
          req_col   <= '0;
          req_row   <= '0;
        end
      end else if (stop) begin
        stop_pend <= 1'b1;
      end
      if (prod_ready) begin
        if (last_col) begin
          req_col <= '0;
          req_row <= last_row ? '0 : req_row + 16'd1;
          if (last_row) frame_cnt <= frame_cnt + 16'd1;
        end else begin
          req_col <= req_col + 16'd1;
        end
      end
    end
  end

  assign ent_w.pix = prod_pixel;
  assign ent_w.sof = (rx_col == 16'd0) && (rx_row == 16'd0);
  assign ent_w.eol = rx_col == COL_LAST;
  assign ent_w.eof = (rx_col == COL_LAST) && (rx_row == ROW_LAST);

  // Receive counters track every producer beat, including dropped ones, to stay frame-aligned.
  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_col <= '0;
      rx_row <= '0;
    end else if (prod_valid) begin
      if (rx_col == COL_LAST) begin
        rx_col <= '0;
        rx_row <= (rx_row == ROW_LAST) ? '0 : rx_row + 16'd1;
      end else begin
        rx_col <= rx_col + 16'd1;
      end
    end
  end

  // slot[0] is always the head; slot[1] only holds data when occ==2.
  always_ff @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      slot    <= '0;
      occ     <= '0;
      err_ovf <= 1'b0;
    end else if (pop && prod_valid) begin
      if (occ == 2'd2) begin
        slot[0] <= slot[1];
        slot[1] <= ent_w;
      end else begin
        slot[0] <= ent_w;
      end
    end else if (pop) begin
      slot[0] <= slot[1];
      occ     <= occ - 2'd1;
    end else if (prod_valid) begin
      if (occ == 2'd0) begin
        slot[0] <= ent_w;
        occ     <= 2'd1;
      end else if (occ == 2'd1) begin
        slot[1] <= ent_w;
        occ     <= 2'd2;
      end else begin
        err_ovf <= 1'b1;
      end
    end
  end

  assign out_valid = occ != 2'd0;
  assign out_pixel = slot[0].pix;
  assign out_sof   = slot[0].sof;
  assign out_eol   = slot[0].eol;
  assign out_eof   = slot[0].eof;

endmodule

// File: tb/tb_sensor_frame_sequencer.sv
// Bench: behavioural producer pushes expected pixel/tags at request time, monitor pops on accept.
module tb_sensor_frame_sequencer;
  localparam int W = 4, H = 2, HB = 2, VB = 3;

  logic        sensor_clk = 1'b0;
  logic        rst_n = 1'b0, start = 1'b0, stop = 1'b0, out_ready = 1'b0;
  logic [15:0] num_frames = '0;
  logic        prod_ready, prod_valid, out_valid, out_sof, out_eol, out_eof, busy, err_ovf;
  logic [7:0]  prod_pixel, out_pixel;
  logic [15:0] frame_cnt;
  logic        pv = 1'b0, force_v = 1'b0;
  logic [7:0]  ppix = '0, pixcnt = '0;
  int          n_cmp = 0, n_bad = 0, req_total = 0, pop_total = 0, tb_col = 0, tb_row = 0;

  typedef struct packed {
    logic [7:0] pix;
    logic sof, eol, eof;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  assign prod_valid = pv | force_v;
  assign prod_pixel = ppix;

  sensor_frame_sequencer #(.IMG_W(W), .IMG_H(H), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .sensor_clk(sensor_clk), .rst_n(rst_n), .start(start), .stop(stop), .num_frames(num_frames),
    .prod_ready(prod_ready), .prod_valid(prod_valid), .prod_pixel(prod_pixel),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy), .frame_cnt(frame_cnt), .err_ovf(err_ovf));

  always #5 sensor_clk = ~sensor_clk;

  // Producer: registered output one cycle after ready; expected tags derived from request order.
  always @(posedge sensor_clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= 1'b0; ppix <= '0; pixcnt <= '0; tb_col <= 0; tb_row <= 0; req_total <= 0;
      sb.delete();
    end else begin
      pv <= prod_ready;
      if (prod_ready) begin
        ppix   <= pixcnt;
        pixcnt <= pixcnt + 8'd1;
        sb.push_back('{pixcnt, (tb_col == 0 && tb_row == 0), (tb_col == W-1), (tb_col == W-1 && tb_row == H-1)});
        tb_col    <= (tb_col == W-1) ? 0 : tb_col + 1;
        if (tb_col == W-1) tb_row <= (tb_row == H-1) ? 0 : tb_row + 1;
        req_total <= req_total + 1;
      end
    end
  end

  always @(negedge sensor_clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected got=%h expected=none", out_pixel);
      end else begin
        mon_e = sb.pop_front();
        if ({out_pixel, out_sof, out_eol, out_eof} !== mon_e) begin
          n_bad++;
          $display("FAIL pixel_tag got=%h sof/eol/eof=%b%b%b expected=%h %b%b%b",
                   out_pixel, out_sof, out_eol, out_eof, mon_e.pix, mon_e.sof, mon_e.eol, mon_e.eof);
        end
      end
      pop_total++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sensor_clk); #1;
  endtask

  task automatic pulse_start(input logic [15:0] n);
    num_frames = n; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!busy && sb.size() == 0 && !out_valid) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst_n = 1'b0; tick(); tick(); tick();
    n_cmp++;
    if ({prod_ready, out_valid, out_pixel, out_sof, out_eol, out_eof, busy, frame_cnt, err_ovf} !== '0) begin
      n_bad++; $display("FAIL reset_state got=%b expected=0", {prod_ready, out_valid, out_pixel, busy, frame_cnt, err_ovf});
    end
    rst_n = 1'b1; tick();
    out_ready = 1'b1;
    pulse_start(16'd0);
    for (int i = 0; i < 100 && req_total < 10; i++) tick();
    n_cmp++;
    if (req_total < 10) begin n_bad++; $display("FAIL reset_reach_px10 got=%0d expected=10", req_total); end
    rst_n = 1'b0; #1;
    n_cmp++;
    if ({prod_ready, out_valid, out_pixel, out_sof, out_eol, out_eof, busy, frame_cnt, err_ovf} !== '0) begin
      n_bad++; $display("FAIL reset_mid_active got=%b expected=0", {prod_ready, out_valid, out_pixel, busy, frame_cnt, err_ovf});
    end
    tick(); tick(); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sensor_clk); seen |= prod_ready | busy; tick();
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL reset_idle_after got=%b expected=0", seen); end
  endtask

  task automatic test_frame();
    logic [14:0] pat;
    int first_ov, p0;
    bit ok;
    out_ready = 1'b1; first_ov = -1; p0 = pop_total;
    pulse_start(16'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge sensor_clk);
      pat[14-i] = prod_ready;
      if (out_valid && first_ov < 0) first_ov = i;
      tick();
    end
    n_cmp++;
    if (pat !== 15'b111100111100000) begin n_bad++; $display("FAIL frame_ready_pattern got=%b expected=111100111100000", pat); end
    n_cmp++;
    if (first_ov != 2) begin n_bad++; $display("FAIL frame_latency got=%0d expected=2", first_ov); end
    n_cmp++;
    if (busy !== 1'b0 || frame_cnt !== 16'd1) begin n_bad++; $display("FAIL frame_end got=busy%b cnt%0d expected=busy0 cnt1", busy, frame_cnt); end
    wait_done(ok);
    n_cmp++;
    if (!ok || pop_total - p0 != 8) begin n_bad++; $display("FAIL frame_pixels got=%0d ok=%b expected=8", pop_total - p0, ok); end
  endtask

  task automatic test_stop();
    int r0, vb;
    bit ok;
    out_ready = 1'b1; r0 = req_total; vb = 0;
    pulse_start(16'd0);
    for (int i = 0; i < 200 && req_total - r0 < 13; i++) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sensor_clk);
      if (!busy) break;
      if (!prod_ready && req_total - r0 == 16) vb++;
      tick();
    end
    n_cmp++;
    if (busy !== 1'b0 || frame_cnt !== 16'd2) begin n_bad++; $display("FAIL stop_end got=busy%b cnt%0d expected=busy0 cnt2", busy, frame_cnt); end
    n_cmp++;
    if (vb != VB) begin n_bad++; $display("FAIL stop_vblank got=%0d expected=%0d", vb, VB); end
    wait_done(ok);
    for (int i = 0; i < 5; i++) tick();
    n_cmp++;
    if (!ok || req_total - r0 != 16) begin n_bad++; $display("FAIL stop_requests got=%0d ok=%b expected=16", req_total - r0, ok); end
  endtask

  task automatic test_backpressure();
    int r0, p0, gapless;
    bit ok;
    out_ready = 1'b0; r0 = req_total; p0 = pop_total; gapless = 0;
    pulse_start(16'd1);
    for (int i = 0; i < 8; i++) tick();
    n_cmp++;
    if (req_total - r0 != 2 || err_ovf !== 1'b0 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_hold got=req%0d ovf%b vld%b expected=req2 ovf0 vld1", req_total - r0, err_ovf, out_valid);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sensor_clk); if (out_valid) gapless++; tick();
    end
    n_cmp++;
    if (gapless != 4) begin n_bad++; $display("FAIL bp_gapless got=%0d expected=4", gapless); end
    wait_done(ok);
    n_cmp++;
    if (!ok || pop_total - p0 != 8 || err_ovf !== 1'b0) begin
      n_bad++; $display("FAIL bp_drain got=%0d ovf%b ok=%b expected=8 ovf0", pop_total - p0, err_ovf, ok);
    end
  endtask

  task automatic test_toggle();
    int p0;
    bit ok;
    p0 = pop_total; out_ready = 1'b1;
    pulse_start(16'd1);
    for (int i = 0; i < 100; i++) begin
      out_ready = (i % 2) == 1;
      if (!busy && sb.size() == 0 && !out_valid) break;
      tick();
    end
    out_ready = 1'b1;
    wait_done(ok);
    n_cmp++;
    if (!ok || pop_total - p0 != 8 || err_ovf !== 1'b0) begin
      n_bad++; $display("FAIL toggle_drain got=%0d ovf%b ok=%b expected=8 ovf0", pop_total - p0, err_ovf, ok);
    end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    pulse_start(16'd1);
    for (int i = 0; i < 6; i++) tick();
    force_v = 1'b1; tick(); force_v = 1'b0;
    @(negedge sensor_clk);
    n_cmp++;
    if (err_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%b expected=1", err_ovf); end
    for (int i = 0; i < 6; i++) tick();
    @(negedge sensor_clk);
    n_cmp++;
    if (err_ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%b expected=1", err_ovf); end
    tick();
    rst_n = 1'b0; #1;
    n_cmp++;
    if (err_ovf !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL ovf_reset got=ovf%b busy%b expected=0 0", err_ovf, busy); end
    tick(); tick(); rst_n = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stop();
    test_backpressure();
    test_toggle();
    test_overflow();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sensor_frame_sequencer.md
Name: sensor_frame_sequencer

Overview:
- Sequences the sensor pixel producer on sensor_clk by driving its ready input, so pixels are requested in frames of IMG_W x IMG_H with horizontal and vertical blanking gaps.
- Buffers the producer's registered output (valid follows ready by one cycle and cannot be stalled) in a 2-entry skid buffer.
- Re-emits pixels on a valid/ready stream with sof/eol/eof tags. Runs N frames, or runs continuously, under start/stop control.

Parameters:
- IMG_W, 32, pixels per line.
- IMG_H, 32, lines per frame. IMG_W*IMG_H equals the producer's IMAGE_SIZE.
- H_BLANK, 4, idle cycles after the last request of each non-final line. 0 means no gap.
- V_BLANK, 16, idle cycles after the last request of a frame. 0 means no gap.

Ports:
- sensor_clk  in  1  clock
- rst_n  in  1  async active-low reset
- start  in  1  one-cycle pulse; begins a run; ignored unless the FSM is in IDLE
- stop  in  1  one-cycle pulse; ends the run after the current frame completes
- num_frames  in  16  frames per run, sampled at start; 0 = continuous
- prod_ready  out  1  to producer ready
- prod_valid  in  1  from producer valid
- prod_pixel  in  8  from producer pixel
- out_pixel  out  8  buffered pixel
- out_valid  out  1  buffer non-empty
- out_ready  in  1  downstream accept
- out_sof  out  1  head pixel is frame pixel (0,0)
- out_eol  out  1  head pixel is the last pixel of its line
- out_eof  out  1  head pixel is the last pixel of the frame
- busy  out  1  FSM not in IDLE
- frame_cnt  out  16  frames fully requested in the current run
- err_ovf  out  1  sticky; producer pixel arrived while the buffer was full

Behaviour:
- Reset is asynchronous on rst_n low. Every output and register goes to 0; FSM enters IDLE. Any buffered pixels and in-flight request are discarded; the producer shares rst_n.
- FSM states:
  - IDLE: on start, latch num_frames, clear frame_cnt, clear stop_pend, and go to ACTIVE.
  - ACTIVE: issue the requests for the current line.
    - After the IMG_W-th request, if it was not the last line: go to HBLANK, or to ACTIVE for the next line when H_BLANK=0.
    - After the last request of the last line: increment frame_cnt and go to VBLANK, or evaluate exit immediately when V_BLANK=0.
  - HBLANK: count H_BLANK cycles, then go to ACTIVE for the next line.
  - VBLANK: count V_BLANK cycles, then evaluate exit.
  - Exit evaluation: go to IDLE if stop_pend is set, or if num_frames!=0 and frame_cnt==num_frames. Otherwise go to ACTIVE at row 0.
- stop is latched into stop_pend in any non-IDLE state. start while busy has no effect.
- Request rule: prod_ready is combinational and equals state==ACTIVE && credit.
  - credit = (occ - pop + ready_q) < 2.
  - occ = buffer occupancy (0..2); pop = out_valid && out_ready; ready_q = prod_ready registered.
  - Each cycle with prod_ready=1 counts as one request (req_col, req_row counters).
  - This rule allows one pixel per cycle at full downstream throughput. occ never exceeds 2 in legal operation.
- Receive rule: each cycle with prod_valid=1 writes prod_pixel plus tags into the buffer.
  - Tags come from the receive counters rx_col and rx_row: sof=(rx_col==0 && rx_row==0); eol=(rx_col==IMG_W-1); eof=eol && rx_row==IMG_H-1.
  - rx_col wraps to 0 at IMG_W-1 and then increments rx_row; rx_row wraps to 0 at IMG_H-1.
  - A write and a pop in the same cycle are both performed; occ is unchanged.
  - A write when occ==2 and pop==0 drops the pixel and sets err_ovf. err_ovf stays set until reset.
- Latency: first prod_ready occurs the cycle after start is sampled. The first out_valid follows 2 cycles after the first prod_ready.
- Tag signals and out_pixel are valid only while out_valid=1 and must hold stable until popped.
- Entering IDLE stops requests immediately. Pixels already in the buffer or in flight still drain to the output.
- busy is 0 only in IDLE, independent of drain status.

Test Plan:
- Reset mid-ACTIVE (rst_n low for 2 cycles at pixel 10) -> all outputs 0 in the same cycle; after release, busy=0 and no requests until start.
- IMG_W=4, IMG_H=2, H_BLANK=2, V_BLANK=3, num_frames=1, out_ready=1 -> prod_ready pattern 1111 00 1111 000, then busy=0. Output shows 8 pixels: sof on the 1st, eol on the 4th and 8th, eof on the 8th. frame_cnt=1.
- num_frames=0 with stop pulsed at pixel 5 of frame 2 -> frame 2 completes (frame_cnt=2) and VBLANK runs before IDLE. No request occurs after the frame's last request.
- out_ready held 0 from pixel 1 -> prod_ready deasserts so occ peaks at 2 and err_ovf=0. Releasing out_ready yields an in-order, gap-free pixel sequence.
- out_ready toggling 1010 across a frame -> no pixel lost or duplicated, tags correct, err_ovf=0.
- Force prod_valid=1 externally with occ==2 and out_ready=0 -> err_ovf=1, and it stays 1 until reset.
